kbd_scan_chain: RTL and testbench

//  Parametrised keyboard-matrix scanner and LED-chain driver on one 3-wire serial link (ck/do/di).

---
 rtl/kbd_scan_chain.sv | 197 +++++++++++++++++++
 tb/tb_kbd_scan_chain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_chain.sv
// Keyboard-matrix scanner and RGB LED-chain driver sharing one serial link.
// Each frame clocks KEY_SLOTS key bits in, shifts NUM_LEDS x 24 colour bits
// out, then idles for a gap. Debounced key changes become events in a small
// first-word-fall-through FIFO.
module kbd_scan_chain #(
  parameter int CLK_DIV         = 175,
  parameter int KEY_SLOTS       = 128,
  parameter int NUM_KEYS        = 80,
  parameter int NUM_LEDS        = 4,
  parameter int GAP_HALVES      = 26,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    kb_ck,
  output logic                    kb_do,
  input  logic                    kb_di,
  input  logic [24*NUM_LEDS-1:0]  led_rgb,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [7:0]              ev_data,
  output logic [NUM_KEYS-1:0]     key_down,
  output logic                    frame_done
);

  localparam int FRAME_HALVES = 2*KEY_SLOTS + 48*NUM_LEDS + GAP_HALVES;
  localparam int HW = $clog2(FRAME_HALVES);
  localparam int DW = $clog2(CLK_DIV);
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(24*NUM_LEDS);

  localparam logic [HW-1:0] SCAN_END = HW'(2*KEY_SLOTS);
  localparam logic [HW-1:0] LED_END  = HW'(2*KEY_SLOTS + 48*NUM_LEDS);
  localparam logic [HW-1:0] H_LAST   = HW'(FRAME_HALVES - 1);
  localparam logic [HW-1:0] NKEYS_H  = HW'(NUM_KEYS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Frame timing and link outputs
  logic [DW-1:0]           div_q, div_d;
  logic [HW-1:0]           h_q, h_d;
  logic                    kb_ck_q, kb_ck_d;
  logic                    kb_do_q, kb_do_d;
  logic                    frame_done_q, frame_done_d;
  logic [24*NUM_LEDS-1:0]  snap_q, snap_d;
  logic                    tick;
  logic [HW-1:0]           led_off;
  logic [SW-1:0]           led_idx;

  // Key sample handed to the debouncer
  logic                    samp_vld_q, samp_vld_d;
  logic                    samp_val_q, samp_val_d;
  logic [KW-1:0]           samp_slot_q, samp_slot_d;

  // Debounce state
  logic [NUM_KEYS-1:0]     key_down_q, key_down_d;
  logic [CW-1:0]           cnt_q [NUM_KEYS];
  logic [CW-1:0]           cnt_d [NUM_KEYS];

  // Event FIFO
  logic [7:0]              fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    fifo_full;
  logic                    push, pop;
  logic [7:0]              push_data;

  assign tick    = (div_q == DIV_LAST);
  // Serial bits leave byte-by-byte MSB first from a {R,G,B} word stored
  // little-endian, so the colour bit for stream position b is simply b ^ 7.
  assign led_off = h_q - SCAN_END;
  assign led_idx = SW'(led_off >> 1) ^ SW'(7);

  // Divider, half counter, registered link outputs, snapshot and key sampling
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    div_d        = tick ? '0 : div_q + 1'b1;
    h_d          = h_q;
    kb_ck_d      = kb_ck_q;
    kb_do_d      = kb_do_q;
    frame_done_d = 1'b0;
    snap_d       = snap_q;
    samp_vld_d   = 1'b0;
    samp_val_d   = samp_val_q;
    samp_slot_d  = samp_slot_q;
    if (tick) begin
      h_d          = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      frame_done_d = (h_q == H_LAST);
      if (h_q == '0) snap_d = led_rgb;
      if (h_q < SCAN_END) begin
        kb_ck_d = h_q[0];
        kb_do_d = 1'b0;
        if (!h_q[0] && ((h_q >> 1) < NKEYS_H)) begin
          samp_vld_d  = 1'b1;
          samp_val_d  = ~kb_di;
          samp_slot_d = KW'(h_q >> 1);
        end
      end else if (h_q < LED_END) begin
        kb_ck_d = h_q[0];
        kb_do_d = snap_q[led_idx];
      end else begin
        kb_ck_d = 1'b1;
        kb_do_d = 1'b0;
      end
    end
  end

  // Debounce the sampled key and decide whether to emit an event
  always_comb begin
    key_down_d = key_down_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_data  = {samp_val_q, 7'(samp_slot_q)};
    if (samp_vld_q) begin
      if (samp_val_q == key_down_q[samp_slot_q]) begin
        cnt_d[samp_slot_q] = '0;
      end else if (cnt_q[samp_slot_q] == CNT_LAST) begin
        // A full FIFO holds state and count so the change retries next frame.
        if (!fifo_full) begin
          key_down_d[samp_slot_q] = samp_val_q;
          cnt_d[samp_slot_q]      = '0;
          push                    = 1'b1;
        end
      end else begin
        cnt_d[samp_slot_q] = cnt_q[samp_slot_q] + 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    fifo_full = (count_q == FULL_CNT);
    pop       = ev_ready && (count_q != '0);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      div_q        <= '0;
      h_q          <= '0;
      kb_ck_q      <= 1'b1;
      kb_do_q      <= 1'b0;
      frame_done_q <= 1'b0;
      snap_q       <= '0;
      samp_vld_q   <= 1'b0;
      samp_val_q   <= 1'b0;
      samp_slot_q  <= '0;
      key_down_q   <= '0;
      cnt_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      kb_ck_q      <= kb_ck_d;
      kb_do_q      <= kb_do_d;
      frame_done_q <= frame_done_d;
      snap_q       <= snap_d;
      samp_vld_q   <= samp_vld_d;
      samp_val_q   <= samp_val_d;
      samp_slot_q  <= samp_slot_d;
      key_down_q   <= key_down_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; ev_valid is gated by the reset count, so stale entries are never visible.
    if (push) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  assign kb_ck      = kb_ck_q;
  assign kb_do      = kb_do_q;
  assign frame_done = frame_done_q;
  assign key_down   = key_down_q;
  assign ev_valid   = (count_q != '0);
  assign ev_data    = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_kbd_scan_chain.sv
// Self-checking bench for kbd_scan_chain in its small configuration.
// A keyboard model feeds slot bits on kb_ck falls; a scoreboard queue holds
// the events expected from each stimulus and is drained by the ev monitor.
module tb_kbd_scan_chain;

  localparam int NK = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          kb_ck, kb_do, kb_di;
  logic [23:0]   led_rgb;
  logic          ev_valid, ev_ready;
  logic [7:0]    ev_data;
  logic [NK-1:0] key_down;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] press_mask = 8'h00;
  int         slot_idx   = 0;
  logic       ck_prev    = 1'b1;
  logic [7:0] exp_q [$];

  kbd_scan_chain #(
    .CLK_DIV(4), .KEY_SLOTS(8), .NUM_KEYS(NK), .NUM_LEDS(1),
    .GAP_HALVES(2), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .kb_ck(kb_ck), .kb_do(kb_do), .kb_di(kb_di),
    .led_rgb(led_rgb), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .key_down(key_down), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Keyboard model: presents slot n until the n-th kb_ck fall of the frame
  assign kb_di = (slot_idx < 8) ? ~press_mask[slot_idx] : 1'b1;

  always @(negedge clk) begin
    if (!reset_n || frame_done) slot_idx <= 0;
    else if (ck_prev && !kb_ck) slot_idx <= slot_idx + 1;
    ck_prev <= kb_ck;
  end

  // Scoreboard: every accepted event must match the oldest expected one
  always @(negedge clk) begin
    if (reset_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) check("spurious_ev", 96'(ev_data), 96'hDEAD);
      else                   check("ev_data", 96'(ev_data), 96'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_frame_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 400);
    if (!frame_done) check("frame_done_timeout", 96'(n), 96'd0);
  endtask

  task automatic next_frame(input logic [7:0] mask);
    int n;
    wait_frame_done(n);
    press_mask = mask;
  endtask

  // Samples kb_ck/kb_do in the middle of halves 0..64; call on a frame_done negedge
  task automatic capture_frame(input bit mid_change, input logic [23:0] mid_rgb,
                               output logic [64:0] ck_v, output logic [64:0] do_v);
    repeat (4) @(negedge clk);
    for (int h = 0; h < 65; h++) begin
      ck_v[h] = kb_ck;
      do_v[h] = kb_do;
      if (mid_change && h == 20) led_rgb = mid_rgb;
      if (h < 64) repeat (4) @(negedge clk);
    end
  endtask

  function automatic logic [64:0] exp_ck();
    logic [64:0] v;
    for (int h = 0; h < 65; h++) v[h] = (h < 64) ? (h % 2 == 1) : 1'b1;
    return v;
  endfunction

  function automatic logic [64:0] exp_do(input logic [23:0] rgb);
    logic [64:0] v;
    logic [23:0] s;
    s = {rgb[7:0], rgb[15:8], rgb[23:16]};
    for (int h = 0; h < 65; h++) v[h] = (h >= 16 && h < 64) ? s[23 - (h - 16) / 2] : 1'b0;
    return v;
  endfunction

  initial begin
    int n;
    logic [64:0] ck_v, do_v;
    led_rgb  = 24'h0;
    ev_ready = 1'b1;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state and idle frame timing
    check("rst_kb_ck", 96'(kb_ck), 96'd1);
    check("rst_kb_do", 96'(kb_do), 96'd0);
    check("rst_ev_valid", 96'(ev_valid), 96'd0);
    check("rst_key_down", 96'(key_down), 96'd0);
    check("rst_frame_done", 96'(frame_done), 96'd0);
    reset_n = 1'b1;
    wait_frame_done(n);
    check("first_frame_done", 96'(n), 96'd264);
    wait_frame_done(n);
    check("frame_period", 96'(n), 96'd264);
    capture_frame(1'b0, 24'h0, ck_v, do_v);
    check("idle_ck_seq", 96'(ck_v), 96'(exp_ck()));
    check("idle_do_seq", 96'(do_v), 96'd0);

    // LED bit order and frame-start snapshot
    wait_frame_done(n);
    led_rgb = 24'hFF0001;
    capture_frame(1'b1, 24'h123456, ck_v, do_v);
    check("led_ck_seq", 96'(ck_v), 96'(exp_ck()));
    check("led_do_ff0001", 96'(do_v), 96'(exp_do(24'hFF0001)));
    wait_frame_done(n);
    capture_frame(1'b0, 24'h0, ck_v, do_v);
    check("led_do_123456", 96'(do_v), 96'(exp_do(24'h123456)));

    // Debounce: one-frame glitch ignored, two-frame press/release reported
    next_frame(8'h08);
    next_frame(8'h00);
    next_frame(8'h08);
    check("glitch_no_key", 96'(key_down), 96'd0);
    next_frame(8'h08);
    exp_q.push_back(8'h83);
    next_frame(8'h00);
    check("key3_down", 96'(key_down), 96'b001000);
    next_frame(8'h00);
    exp_q.push_back(8'h03);
    next_frame(8'h00);
    check("key3_up", 96'(key_down), 96'd0);
    check("pending_t3", 96'(exp_q.size()), 96'd0);

    // Slots beyond NUM_KEYS are ignored
    repeat (5) next_frame(8'h80);
    next_frame(8'h00);
    check("slot7_ignored", 96'(key_down), 96'd0);

    // Full FIFO back-pressure: third event retries next frame
    @(posedge clk); #1 ev_ready = 1'b0;
    next_frame(8'h07);
    next_frame(8'h07);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    next_frame(8'h07);
    check("held_key_down", 96'(key_down), 96'b000011);
    check("held_valid", 96'(ev_valid), 96'd1);
    check("held_head", 96'(ev_data), 96'h80);
    exp_q.push_back(8'h82);
    @(posedge clk); #1 ev_ready = 1'b1;
    next_frame(8'h07);
    check("key2_down", 96'(key_down), 96'b000111);
    check("pending_t5", 96'(exp_q.size()), 96'd0);

    // Mid-LED-phase reset with events queued
    @(posedge clk); #1 ev_ready = 1'b0;
    next_frame(8'h00);
    next_frame(8'h00);
    next_frame(8'h00);
    check("pre_rst_valid", 96'(ev_valid), 96'd1);
    check("pre_rst_head", 96'(ev_data), 96'h00);
    repeat (84) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("post_rst_valid", 96'(ev_valid), 96'd0);
    check("post_rst_key_down", 96'(key_down), 96'd0);
    check("post_rst_kb_ck", 96'(kb_ck), 96'd1);
    check("post_rst_kb_do", 96'(kb_do), 96'd0);
    repeat (4) @(negedge clk);
    check("post_rst_h0_ck", 96'(kb_ck), 96'd0);
    wait_frame_done(n);
    check("post_rst_frame_len", 96'(n), 96'd260);
    @(negedge clk);
    check("frame_done_pulse", 96'(frame_done), 96'd0);
    @(posedge clk); #1 ev_ready = 1'b1;
    next_frame(8'h00);
    check("post_rst_no_events", 96'(ev_valid), 96'd0);
    check("pending_end", 96'(exp_q.size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
